fetch_queue: RTL

- Instruction-fetch front end directly upstream of the pipelined datapath.
- Issues requests to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small FIFO and presents the head to the datapath as InstrF/PCF/ValidF.
- Flushes the FIFO and refetches from RedirectPC on branch-taken or PC-write redirects.

---
 rtl/fetch_queue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: one outstanding req/ack fetch at a time feeding a
// circular {PC, word} FIFO whose head is presented to the datapath.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Redirect,
  input  logic [31:0]                RedirectPC,
  input  logic                       Advance,
  output logic [31:0]                InstrF,
  output logic [31:0]                PCF,
  output logic                       ValidF,
  output logic                       IReq,
  output logic [31:0]                IAddr,
  input  logic                       IAck,
  input  logic [31:0]                IRData,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_drop_addr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_next;
  logic [31:0]     r_pc_mem   [DEPTH];
  logic [31:0]     r_word_mem [DEPTH];
  logic            w_write;
  logic            w_pop;
  logic            w_space;

  // Redirect flushes the queue, so it suppresses both the write and the pop.
  assign w_write = (r_state == S_WAIT) && IAck && !Redirect;
  assign w_pop   = Advance && (r_count != '0) && !Redirect;

  always_comb begin
    w_count_next = r_count;
    if (Redirect)
      w_count_next = '0;
    else
      w_count_next = r_count + {{(CW-1){1'b0}}, w_write} - {{(CW-1){1'b0}}, w_pop};
  end

  assign w_space = w_count_next < CW'(DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!Redirect && w_space)
          w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (Redirect)
          w_state_next = IAck ? S_IDLE : S_DROP;
        else if (IAck)
          w_state_next = w_space ? S_WAIT : S_IDLE;
      end
      S_DROP: begin
        // The memory still owes one response; swallow it before refetching.
        if (IAck)
          w_state_next = (!Redirect && w_space) ? S_WAIT : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    IReq  = 1'b0;
    IAddr = r_fetch_pc;
    case (r_state)
      S_WAIT: IReq = 1'b1;
      S_DROP: begin
        IReq  = 1'b1;
        IAddr = r_drop_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc  <= RESET_PC;
      r_drop_addr <= RESET_PC;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_count <= w_count_next;
      if (Redirect) begin
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_fetch_pc <= RedirectPC;
        if (r_state == S_WAIT && !IAck)
          r_drop_addr <= r_fetch_pc;
      end else begin
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_write) begin
          r_wr_ptr   <= r_wr_ptr + AW'(1);
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
      r_word_mem[r_wr_ptr] <= IRData;
    end
  end

  assign ValidF = (r_count != '0);
  assign InstrF = ValidF ? r_word_mem[r_rd_ptr] : 32'h0;
  assign PCF    = ValidF ? r_pc_mem[r_rd_ptr]   : 32'h0;
  assign Count  = r_count;

endmodule
